sensor_sample_ctrl: RTL and testbench

//  Sequences the external sensor and buffers its 32-bit samples in a 64-word local store.

---
 rtl/sensor_sample_ctrl_if.sv | 39 +++
 rtl/sensor_sample_ctrl.sv | 87 ++++++++
 tb/tb_sensor_sample_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_sample_ctrl_if.sv
// ---------------------------------------------------------------------------
// sensor_sample_ctrl_if
// Groups the wrapper-side control/read bus and the sensor handshake for
// sensor_sample_ctrl.
//   master : wrapper + sensor side (drives enable/clear/addr, sensor data)
//   slave  : sensor_sample_ctrl (drives read data, interrupt, sensor_en)
// Signals:
//   sctrl_en        sampling enable (level)
//   sctrl_clear     clear request
//   sctrl_addr      buffer read index
//   sctrl_data_out  registered buffer word at sctrl_addr
//   sctrl_interrupt buffer full, level until cleared
//   sensor_en       request next sample from sensor
//   sensor_ready    sensor_out valid this cycle
//   sensor_out      sample value
// ---------------------------------------------------------------------------
interface sensor_sample_ctrl_if #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 32
);
    logic                 sctrl_en;
    logic                 sctrl_clear;
    logic [ADDR_SIZE-1:0] sctrl_addr;
    logic [DATA_SIZE-1:0] sctrl_data_out;
    logic                 sctrl_interrupt;
    logic                 sensor_en;
    logic                 sensor_ready;
    logic [DATA_SIZE-1:0] sensor_out;

    modport master (
        output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        input  sctrl_data_out, sctrl_interrupt, sensor_en
    );

    modport slave (
        input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        output sctrl_data_out, sctrl_interrupt, sensor_en
    );
endinterface

// File: rtl/sensor_sample_ctrl.sv
// ---------------------------------------------------------------------------
// sensor_sample_ctrl
// Sequences the external sensor and buffers its samples in a 2**ADDR_SIZE
// word local store; raises an interrupt once the store is full.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sensor_sample_ctrl_if.slave (control, read-back, sensor handshake)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | not sampling; waits for enable with no clear pending
// SAMPLE  | sensor_en high; each sensor_ready stores one word at wr_cnt
// FULL    | all words captured; interrupt high; waits for clear
// ---------------------------------------------------------------------------
module sensor_sample_ctrl #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sensor_sample_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_SAMPLE = 3'b010;
    localparam logic [2:0] ST_FULL   = 3'b100;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [ADDR_SIZE-1:0] wr_cnt;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic                 capture;

    // clear wins over a same-cycle sample, so the dropped word never lands
    assign capture = (state == ST_SAMPLE) && bus.sensor_ready && !bus.sctrl_clear;

    always_comb begin
        state_nxt = state;
        if (bus.sctrl_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (bus.sctrl_en) state_nxt = ST_SAMPLE;
                ST_SAMPLE: begin
                    // the last slot filling outranks a same-cycle disable
                    if (capture && (&wr_cnt)) state_nxt = ST_FULL;
                    else if (!bus.sctrl_en)   state_nxt = ST_IDLE;
                end
                ST_FULL:   state_nxt = ST_FULL;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // outputs registered from next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            bus.sensor_en       <= 1'b0;
            bus.sctrl_interrupt <= 1'b0;
            wr_cnt              <= '0;
        end else begin
            state               <= state_nxt;
            bus.sensor_en       <= (state_nxt == ST_SAMPLE);
            bus.sctrl_interrupt <= (state_nxt == ST_FULL);
            if (bus.sctrl_clear) begin
                wr_cnt <= '0;
            end else if (capture) begin
                // wraps to 0 on the last slot; FULL state carries "full", not the count
                wr_cnt <= wr_cnt + ADDR_SIZE'(1);
            end
        end
    end

    // read sees the pre-write word on a same-cycle write/read of one index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bus.sctrl_data_out <= '0;
        end else begin
            if (capture) mem[wr_cnt] <= bus.sensor_out;
            bus.sctrl_data_out <= mem[bus.sctrl_addr];
        end
    end
endmodule

// File: tb/tb_sensor_sample_ctrl.sv
module tb_sensor_sample_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sensor_sample_ctrl_if #(.ADDR_SIZE(6), .DATA_SIZE(32)) bus ();

    sensor_sample_ctrl #(.ADDR_SIZE(6), .DATA_SIZE(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference: buffer contents, capture count, and whether the block is
    // currently collecting samples or holding a full buffer
    logic [31:0] m_mem [64];
    int          m_cnt;
    bit          m_active;
    bit          m_full;
    logic [31:0] m_rd;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_cnt = 0; m_active = 0; m_full = 0; m_rd = '0;
    endfunction

    task automatic tick(input bit en, input bit clr, input bit rdy,
                        input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sctrl_en = en; bus.sctrl_clear = clr; bus.sensor_ready = rdy;
        bus.sctrl_addr = a; bus.sensor_out = d;
        @(posedge clk);
        m_rd = m_mem[a];
        if (clr) begin
            m_cnt = 0; m_full = 0; m_active = 0;
        end else if (m_active) begin
            if (rdy) begin m_mem[m_cnt] = d; m_cnt++; end
            if (m_cnt == 64) begin m_cnt = 0; m_full = 1; m_active = 0; end
            else if (!en) m_active = 0;
        end else if (!m_full && en) begin
            m_active = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sctrl_en = 0; bus.sctrl_clear = 0; bus.sensor_ready = 0;
        bus.sctrl_addr = '0; bus.sensor_out = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.sensor_en !== 1'b0) begin n_err++; $display("FAIL reset_sensor_en got=%b exp=0", bus.sensor_en); end
        n_cmp++; if (bus.sctrl_interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", bus.sctrl_interrupt); end
        n_cmp++; if (bus.sctrl_data_out !== 32'h0) begin n_err++; $display("FAIL reset_dout got=%h exp=0", bus.sctrl_data_out); end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        int caps = 0;
        int cyc = 0;
        bit rdy;
        logic [33:0] got, exp;
        logic [5:0]  ra [3];
        logic [31:0] rv [3];
        ra[0] = 6'd0; ra[1] = 6'd17; ra[2] = 6'd63;
        rv[0] = 32'h1000; rv[1] = 32'h1011; rv[2] = 32'h103F;
        while (caps < 64 && cyc < 1000) begin
            rdy = m_active && ($urandom_range(0, 3) != 0);
            tick(1'b1, 1'b0, rdy, 6'($urandom), 32'h1000 + 32'(caps));
            if (rdy) caps++;
            cyc++;
            got = {bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_data_out};
            exp = {m_active, m_full, m_rd};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        n_cmp++; if (caps != 64) begin n_err++; $display("FAIL fill_timeout got=%0d exp=64", caps); end
        n_cmp++; if ({bus.sensor_en, bus.sctrl_interrupt} !== 2'b01) begin
            n_err++; $display("FAIL fill_full_flags got=%b exp=01", {bus.sensor_en, bus.sctrl_interrupt});
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, ra[i], 32'h0);
            n_cmp++; if (bus.sctrl_data_out !== rv[i]) begin
                n_err++; $display("FAIL fill_read addr=%0d got=%h exp=%h", ra[i], bus.sctrl_data_out, rv[i]);
            end
        end
    endtask

    task automatic test_full_hold();
        logic [33:0] got, exp;
        for (int i = 0; i < 5; i++) begin
            tick(1'($urandom), 1'b0, 1'b1, 6'($urandom), 32'hDEAD);
            got = {bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_data_out};
            exp = {m_active, m_full, m_rd};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL full_hold i=%0d got=%h exp=%h", i, got, exp); end
        end
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, 1'b0, 1'b0, 6'(i), 32'h0);
            n_cmp++; if (bus.sctrl_data_out !== 32'h1000 + 32'(i) || bus.sctrl_interrupt !== 1'b1) begin
                n_err++; $display("FAIL full_readback addr=%0d got=%h irq=%b exp=%h irq=1", i,
                                  bus.sctrl_data_out, bus.sctrl_interrupt, 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_resume();
        logic [31:0] q [$];
        logic [31:0] d;
        logic [33:0] got, exp;
        int cyc = 0;
        bit rdy;
        tick(1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
        n_cmp++; if (bus.sctrl_interrupt !== 1'b0) begin n_err++; $display("FAIL resume_clear_irq got=%b exp=0", bus.sctrl_interrupt); end
        while (q.size() < 64 && cyc < 2000) begin
            // enable drops for 20 cycles once 10 samples are in
            bit en = !(q.size() == 10 && cyc < 1000);
            if (q.size() == 10 && cyc < 1000) cyc = 1000;
            for (int k = 0; k < (en ? 1 : 20); k++) begin
                rdy = en ? (m_active && $urandom_range(0, 1) == 1) : (!m_active && $urandom_range(0, 1) == 1);
                d = $urandom;
                // pointing the read at the write slot exercises read-before-write
                tick(en, 1'b0, rdy, ($urandom_range(0, 1) == 1) ? 6'(m_cnt) : 6'($urandom), d);
                if (rdy && en) q.push_back(d);
                cyc++;
                got = {bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_data_out};
                exp = {m_active, m_full, m_rd};
                n_cmp++; if (got !== exp) begin n_err++; $display("FAIL resume cyc=%0d got=%h exp=%h", cyc, got, exp); end
            end
        end
        n_cmp++; if (q.size() != 64 || bus.sctrl_interrupt !== 1'b1) begin
            n_err++; $display("FAIL resume_full caps=%0d irq=%b exp caps=64 irq=1", q.size(), bus.sctrl_interrupt);
        end
        tick(1'b1, 1'b0, 1'b0, 6'd10, 32'h0);
        n_cmp++; if (q.size() > 10 && bus.sctrl_data_out !== q[10]) begin
            n_err++; $display("FAIL resume_addr10 got=%h exp=%h", bus.sctrl_data_out, q[10]);
        end
    endtask

    task automatic test_clear_drop();
        logic [31:0] q [$];
        logic [31:0] d;
        logic [33:0] got, exp;
        int cyc = 0;
        bit rdy;
        tick(1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
        while (q.size() < 29 && cyc < 500) begin
            rdy = m_active && $urandom_range(0, 2) != 0;
            d = $urandom;
            tick(1'b1, 1'b0, rdy, 6'($urandom), d);
            if (rdy) q.push_back(d);
            cyc++;
            got = {bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_data_out};
            exp = {m_active, m_full, m_rd};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL clear_fill cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        tick(1'b1, 1'b1, 1'b1, 6'd5, 32'hBAD0BAD0);
        n_cmp++; if ({bus.sensor_en, bus.sctrl_interrupt} !== 2'b00 || q.size() != 29) begin
            n_err++; $display("FAIL clear_drop flags=%b caps=%0d exp flags=00 caps=29", {bus.sensor_en, bus.sctrl_interrupt}, q.size());
        end
        q.delete();
        cyc = 0;
        while (q.size() < 3 && cyc < 100) begin
            rdy = m_active;
            d = $urandom;
            tick(1'b1, 1'b0, rdy, 6'd0, d);
            if (rdy) q.push_back(d);
            cyc++;
        end
        tick(1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
        n_cmp++; if (q.size() != 3 || bus.sctrl_data_out !== q[0]) begin
            n_err++; $display("FAIL clear_restart_idx0 got=%h exp=%h", bus.sctrl_data_out, q[0]);
        end
        tick(1'b1, 1'b0, 1'b0, 6'd5, 32'h0);
        n_cmp++; if (bus.sctrl_data_out !== m_rd || bus.sctrl_interrupt !== 1'b0) begin
            n_err++; $display("FAIL clear_old_addr5 got=%h irq=%b exp=%h irq=0", bus.sctrl_data_out, bus.sctrl_interrupt, m_rd);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d0;
        int caps = 0;
        int cyc = 0;
        bit rdy;
        tick(1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
        while (caps < 7 && cyc < 200) begin
            rdy = m_active;
            tick(1'b1, 1'b0, rdy, 6'd3, $urandom);
            if (rdy) caps++;
            cyc++;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_data_out} !== 34'h0) begin
            n_err++; $display("FAIL async_reset got=%h exp=0", {bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_data_out});
        end
        m_reset();
        bus.sctrl_en = 0; bus.sensor_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        caps = 0; cyc = 0; d0 = '0;
        while (caps < 4 && cyc < 100) begin
            logic [31:0] d = $urandom;
            rdy = m_active;
            tick(1'b1, 1'b0, rdy, 6'd6, d);
            if (rdy) begin if (caps == 0) d0 = d; caps++; end
            cyc++;
            n_cmp++; if (bus.sensor_en !== m_active || bus.sctrl_data_out !== m_rd) begin
                n_err++; $display("FAIL async_resume cyc=%0d got en=%b dout=%h exp en=%b dout=%h", cyc, bus.sensor_en, bus.sctrl_data_out, m_active, m_rd);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
        n_cmp++; if (caps != 4 || bus.sctrl_data_out !== d0) begin
            n_err++; $display("FAIL async_idx0 got=%h exp=%h", bus.sctrl_data_out, d0);
        end
        tick(1'b1, 1'b0, 1'b0, 6'd6, 32'h0);
        n_cmp++; if (bus.sctrl_data_out !== 32'h0) begin
            n_err++; $display("FAIL async_erased_addr6 got=%h exp=0", bus.sctrl_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_hold();
        test_resume();
        test_clear_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
